// File: rtl/iref_ctrl.sv
// iref_ctrl: power-up/power-down sequencer for the RF current reference.
// Optional periodic refresh charge in ON when IREF_RECHARGE_EN is defined.
module iref_ctrl #(
  parameter int CNT_W           = 16,
  parameter int CHARGE_CYCLES   = 64,
  parameter int SETTLE_CYCLES   = 32,
  parameter int RECHARGE_PERIOD = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic iref_pd,
  output logic iref_charge,
  output logic ready,
  output logic busy
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_CHARGE   = 3'd1,
    S_SETTLE   = 3'd2,
`ifdef IREF_RECHARGE_EN
    S_ON       = 3'd3,
    S_RECHARGE = 3'd4
`else
    S_ON       = 3'd3
`endif
  } state_e;

  localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STL_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef IREF_RECHARGE_EN
  localparam logic [CNT_W-1:0] RCH_LAST = CNT_W'(RECHARGE_PERIOD - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter; dropping en always returns to OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d = S_CHARGE;
          cnt_d   = '0;
        end
        S_CHARGE: begin
          if (cnt_q == CHG_LAST) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == STL_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef IREF_RECHARGE_EN
        S_ON: begin
          if (cnt_q == RCH_LAST) begin
            state_d = S_RECHARGE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RECHARGE: begin
          if (cnt_q == CHG_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        S_ON: begin
          state_d = S_ON;
        end
`endif
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    iref_pd     = 1'b1;
    iref_charge = 1'b1;
    ready       = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      S_OFF: begin
        iref_pd     = 1'b1;
        iref_charge = 1'b1;
      end
      S_CHARGE: begin
        iref_pd     = 1'b0;
        iref_charge = 1'b1;
        busy        = 1'b1;
      end
      S_SETTLE: begin
        iref_pd     = 1'b0;
        iref_charge = 1'b0;
        busy        = 1'b1;
      end
      S_ON: begin
        iref_pd     = 1'b0;
        iref_charge = 1'b0;
        ready       = 1'b1;
      end
`ifdef IREF_RECHARGE_EN
      S_RECHARGE: begin
        iref_pd     = 1'b0;
        iref_charge = 1'b1;
        ready       = 1'b1;
        busy        = 1'b1;
      end
`endif
      default: begin
        iref_pd     = 1'b1;
        iref_charge = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_iref_ctrl.sv
// tb_iref_ctrl: directed scoreboard bench for iref_ctrl.
// Codes: O=off C=charge S=settle N=on R=recharge.
module tb_iref_ctrl;

  logic clk;
  logic rst;
  logic en;
  logic iref_pd;
  logic iref_charge;
  logic ready;
  logic busy;

  int checks;
  int failures;

  byte exp_q[$];

  iref_ctrl #(
    .CNT_W(16),
    .CHARGE_CYCLES(4),
    .SETTLE_CYCLES(3),
    .RECHARGE_PERIOD(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .iref_pd(iref_pd),
    .iref_charge(iref_charge),
    .ready(ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pd, charge, ready, busy} for each state code
  function automatic logic [3:0] vec_of(input byte c);
    case (c)
      "O": vec_of = 4'b1100;
      "C": vec_of = 4'b0101;
      "S": vec_of = 4'b0001;
      "N": vec_of = 4'b0010;
      "R": vec_of = 4'b0111;
      default: vec_of = 4'bxxxx;
    endcase
  endfunction

  // Drive inputs for n edges, queueing the state expected after each edge.
  task automatic step(input logic r, input logic e,
                      input byte c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      en  = e;
      exp_q.push_back(c);
    end
  endtask

  // Monitor: after each edge, pop and compare; check invariants.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      byte c;
      logic [3:0] act;
      logic [3:0] req;
      c   = exp_q.pop_front();
      act = {iref_pd, iref_charge, ready, busy};
      req = vec_of(c);
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL outputs(%s) t=%0t actual=%b required=%b",
                 c, $time, act, req);
      end
      checks++;
      if (iref_pd && ready) begin
        failures++;
        $display("FAIL pd_ready_excl t=%0t actual=11 required=not 11",
                 $time);
      end
      checks++;
      if (iref_pd && !iref_charge) begin
        failures++;
        $display("FAIL pd_implies_charge t=%0t actual=10 required=1x",
                 $time);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    en  = 1'b0;

    // reset with en high
    step(1, 1, "O", 2);

    // full power-up
    step(0, 1, "C", 4);
    step(0, 1, "S", 3);
    step(0, 1, "N", 4);

    // power-down from ON
    step(0, 0, "O", 2);

    // abort in CHARGE, then one-cycle OFF dwell and restart
    step(0, 1, "C", 2);
    step(0, 0, "O", 1);
    step(0, 1, "C", 4);
    step(0, 1, "S", 3);
    step(0, 1, "N", 1);

`ifdef IREF_RECHARGE_EN
    step(0, 1, "N", 9);
    step(0, 1, "R", 4);
    step(0, 1, "N", 10);
    step(0, 1, "R", 4);
    step(0, 1, "N", 3);
    step(0, 1, "R", 2);
    step(0, 0, "O", 1);
`else
    step(0, 1, "N", 30);
    step(0, 0, "O", 1);
`endif

    // reset mid-SETTLE, release with en high
    step(0, 1, "C", 4);
    step(0, 1, "S", 1);
    step(1, 1, "O", 1);
    step(0, 1, "C", 4);
    step(0, 1, "S", 3);
    step(0, 1, "N", 2);
    step(0, 0, "O", 2);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
